// File: rtl/fnd_pkg.sv
// Shared definitions for the 7-segment scan readback monitor: segment codes,
// legal digit enables, FSM states and the frame record.
package fnd_pkg;

  // Active-low segment patterns on seg[6:0] = {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Legal enables: exactly one anode driven low.
  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } scan_state_t;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  dp;
  } frame_t;

  localparam frame_t FRAME_RESET = '{digits: 16'h0000, blank: 4'hF, dp: 4'h0};

  function automatic logic an_is_legal(input logic [3:0] an);
    return an inside {AN_D0, AN_D1, AN_D2, AN_D3};
  endfunction

  function automatic logic [1:0] an_slot(input logic [3:0] an);
    case (an)
      AN_D1:   return 2'd1;
      AN_D2:   return 2'd2;
      AN_D3:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Blank digits are stored as nibble 0, so they contribute nothing.
  function automatic logic [13:0] frame_value(input frame_t f);
    logic [13:0] v;
    v = '0;
    for (int i = 3; i >= 0; i--) begin
      v = v * 14'd10 + {10'd0, f.digits[i*4 +: 4]};
    end
    return v;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low 7-segment pattern into a BCD digit,
// with flags for the all-off pattern and for anything undecodable.
module seg7_pattern_decode
  import fnd_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       blank,
  output logic       invalid
);

  // NOTE: every output gets a default before the case so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    digit   = 4'd0;
    blank   = 1'b0;
    invalid = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Samples the multiplexed active-low seg/an scan, rebuilds the four digits and
// publishes them once the same frame has been seen on consecutive scans.
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int FRAMES_STABLE  = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits,
  output logic [3:0]  blank_mask,
  output logic [3:0]  dp_mask,
  output logic [13:0] value,
  output logic        frame_valid,
  output logic        pattern_error,
  output logic        scan_timeout
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int STB_W = $clog2(FRAMES_STABLE + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [STB_W-1:0] STABLE_MAX  = STB_W'(FRAMES_STABLE);
  localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

  logic [3:0] an_s1, an_s2, an_q;
  logic [7:0] seg_s1, seg_s2, seg_q;

  scan_state_t      state;
  logic [SET_W-1:0] settle_cnt;
  logic [STB_W-1:0] stable_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       cap_an;
  logic [7:0]       cap_seg;
  logic [3:0]       seen;
  frame_t           frame_buf, prev_frame, pub_frame;

  logic [3:0] dec_digit;
  logic       dec_blank, dec_invalid;

  logic [1:0]       cap_slot;
  frame_t           buf_upd;
  logic [3:0]       seen_upd;
  logic [STB_W-1:0] stable_upd;
  logic             frame_done, publish, in_changed;

  // The scan is asynchronous to clk; an_q/seg_q hold the previous synchronized
  // sample for change detection.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // each flop samples the value its neighbour held before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_s1  <= 4'hF;
      an_s2  <= 4'hF;
      an_q   <= 4'hF;
      seg_s1 <= 8'hFF;
      seg_s2 <= 8'hFF;
      seg_q  <= 8'hFF;
    end else begin
      an_s1  <= an_in;
      an_s2  <= an_s1;
      an_q   <= an_s2;
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      seg_q  <= seg_s2;
    end
  end

  assign in_changed = (an_s2 != an_q) || (seg_s2 != seg_q);

  seg7_pattern_decode u_decode (
    .pattern (cap_seg[6:0]),
    .digit   (dec_digit),
    .blank   (dec_blank),
    .invalid (dec_invalid)
  );

  // Next frame buffer as it would look after the capture in progress, so the
  // compare/publish decision lands in the same cycle as the write.
  always_comb begin
    cap_slot                        = an_slot(cap_an);
    buf_upd                         = frame_buf;
    buf_upd.digits[cap_slot*4 +: 4] = dec_digit;
    buf_upd.blank[cap_slot]         = dec_blank | dec_invalid;
    buf_upd.dp[cap_slot]            = ~cap_seg[7];
    seen_upd                        = seen;
    seen_upd[cap_slot]              = 1'b1;
    frame_done                      = (seen_upd == 4'hF);
    if (buf_upd != prev_frame) begin
      stable_upd = STB_W'(1);
    end else if (stable_cnt == STABLE_MAX) begin
      stable_upd = stable_cnt;
    end else begin
      stable_upd = stable_cnt + STB_W'(1);
    end
    publish = frame_done && (stable_upd == STABLE_MAX) && (buf_upd != pub_frame);
  end

  // NOTE: the frame buffers are small register sets, not RAM, so they take the
  // asynchronous reset like every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_WAIT;
      settle_cnt    <= '0;
      stable_cnt    <= '0;
      to_cnt        <= '0;
      cap_an        <= 4'hF;
      cap_seg       <= 8'hFF;
      seen          <= 4'h0;
      frame_buf     <= FRAME_RESET;
      prev_frame    <= FRAME_RESET;
      pub_frame     <= FRAME_RESET;
      value         <= '0;
      frame_valid   <= 1'b0;
      pattern_error <= 1'b0;
      scan_timeout  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;

      if (state == ST_CAPTURE) begin
        to_cnt       <= '0;
        scan_timeout <= 1'b0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt       <= to_cnt + TO_W'(1);
        scan_timeout <= (to_cnt == TO_LAST);
      end

      case (state)
        ST_WAIT: begin
          if (an_is_legal(an_s2)) begin
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!an_is_legal(an_s2)) begin
            state <= ST_WAIT;
          end else if (in_changed) begin
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            cap_an  <= an_s2;
            cap_seg <= seg_s2;
            state   <= ST_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (dec_invalid) pattern_error <= 1'b1;
          if (frame_done) begin
            frame_buf  <= buf_upd;
            prev_frame <= buf_upd;
            stable_cnt <= stable_upd;
            seen       <= 4'h0;
          end else begin
            frame_buf <= buf_upd;
            seen      <= seen_upd;
          end
          if (publish) begin
            pub_frame   <= buf_upd;
            value       <= frame_value(buf_upd);
            frame_valid <= 1'b1;
          end
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (an_s2 != cap_an) state <= ST_WAIT;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  assign digits     = pub_frame.digits;
  assign blank_mask = pub_frame.blank;
  assign dp_mask    = pub_frame.dp;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: scans frames from a vector table, scoreboards
// every publish, then walks timeout, pattern-error and mid-frame reset cases.
module tb_fnd_scan_decoder;

  localparam int SETTLE = 16;
  localparam int FS     = 2;
  localparam int TO     = 3000;
  localparam int WIN    = 80;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  seg_in = 8'hFF;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] digits;
  logic [3:0]  blank_mask, dp_mask;
  logic [13:0] value;
  logic        frame_valid, pattern_error, scan_timeout;

  fnd_scan_decoder #(
    .SETTLE_CYCLES  (SETTLE),
    .FRAMES_STABLE  (FS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .seg_in        (seg_in),
    .an_in         (an_in),
    .digits        (digits),
    .blank_mask    (blank_mask),
    .dp_mask       (dp_mask),
    .value         (value),
    .frame_valid   (frame_valid),
    .pattern_error (pattern_error),
    .scan_timeout  (scan_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [13:0] value;
  } exp_t;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  blank;
    logic [3:0]  dp;
    int          frames;
    bit          pub;
    bit          glitch;
    bit          late;
    logic [13:0] exp_value;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[7];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_pulses = 0;
  int   n_pushed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Scoreboard: each frame_valid pulse pops the oldest expected publish.
  always @(negedge clk) begin
    if (reset === 1'b1 && frame_valid === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_publish: got digits %0h, expected no pulse", digits);
      end else begin
        mon_e = exp_q.pop_front();
        check("pub_digits", 32'(digits), 32'(mon_e.digits));
        check("pub_blank", 32'(blank_mask), 32'(mon_e.blank));
        check("pub_dp", 32'(dp_mask), 32'(mon_e.dp));
        check("pub_value", 32'(value), 32'(mon_e.value));
      end
    end
  end

  task automatic expect_pub(input logic [15:0] d, input logic [3:0] b,
                            input logic [3:0] p, input logic [13:0] v);
    exp_t e;
    e.digits = d;
    e.blank  = b;
    e.dp     = p;
    e.value  = v;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // One digit window: optional short glitch near the start (shorter than the
  // settle time) and optional segment change long after capture.
  task automatic scan_digit(input int slot, input logic [7:0] seg, input bit glitch, input bit late);
    an_in       = 4'hF;
    an_in[slot] = 1'b0;
    for (int c = 0; c < WIN; c++) begin
      if (glitch && c >= 4 && c < 14) seg_in = {seg[7], 7'h2A};
      else if (late && c >= 50)       seg_in = {seg[7], 7'h00};
      else                            seg_in = seg;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan_frame(input logic [15:0] dig, input logic [3:0] blank,
                            input logic [3:0] dp, input bit glitch, input bit late);
    logic [6:0] pat;
    for (int i = 0; i < 4; i++) begin
      pat = blank[i] ? 7'h7F : seg_of(dig[i*4 +: 4]);
      scan_digit(i, {~dp[i], pat}, glitch, late);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_blank"}, 32'(blank_mask), 32'hF);
    check({tag, "_dp"}, 32'(dp_mask), 32'h0);
    check({tag, "_value"}, 32'(value), 32'h0);
    check({tag, "_frame_valid"}, 32'(frame_valid), 32'h0);
    check({tag, "_pattern_error"}, 32'(pattern_error), 32'h0);
    check({tag, "_scan_timeout"}, 32'(scan_timeout), 32'h0);
  endtask

  initial begin
    vecs[0] = '{16'h0130, 4'b0000, 4'b0000, 2, 1'b1, 1'b0, 1'b0, 14'd130};
    vecs[1] = '{16'h0130, 4'b0000, 4'b0000, 1, 1'b0, 1'b0, 1'b0, 14'd130};
    vecs[2] = '{16'h0129, 4'b0000, 4'b0000, 1, 1'b0, 1'b1, 1'b0, 14'd129};
    vecs[3] = '{16'h0129, 4'b0000, 4'b0000, 1, 1'b1, 1'b1, 1'b0, 14'd129};
    vecs[4] = '{16'h0095, 4'b1100, 4'b0010, 2, 1'b1, 1'b0, 1'b0, 14'd95};
    vecs[5] = '{16'h9876, 4'b0000, 4'b0001, 2, 1'b1, 1'b1, 1'b0, 14'd9876};
    vecs[6] = '{16'h9999, 4'b0000, 4'b0000, 2, 1'b1, 1'b0, 1'b1, 14'd9999};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      if (vecs[k].pub)
        expect_pub(vecs[k].dig, vecs[k].blank, vecs[k].dp, vecs[k].exp_value);
      for (int f = 0; f < vecs[k].frames; f++)
        scan_frame(vecs[k].dig, vecs[k].blank, vecs[k].dp, vecs[k].glitch, vecs[k].late);
    end
    @(negedge clk);
    check("glitch_no_pattern_error", 32'(pattern_error), 32'h0);
    check("value_after_table", 32'(value), 32'd9999);

    // Slot 0 captured twice per frame: the later capture wins.
    expect_pub(16'h7654, 4'h0, 4'h0, 14'd7654);
    for (int f = 0; f < 2; f++) begin
      scan_digit(0, {1'b1, seg_of(4'd3)}, 1'b0, 1'b0);
      an_in  = 4'hF;
      seg_in = 8'hFF;
      repeat (20) @(posedge clk);
      #1;
      scan_digit(0, {1'b1, seg_of(4'd4)}, 1'b0, 1'b0);
      scan_digit(1, {1'b1, seg_of(4'd5)}, 1'b0, 1'b0);
      scan_digit(2, {1'b1, seg_of(4'd6)}, 1'b0, 1'b0);
      scan_digit(3, {1'b1, seg_of(4'd7)}, 1'b0, 1'b0);
    end

    // Scan gap: timeout rises, outputs hold, first capture clears it.
    an_in  = 4'hF;
    seg_in = 8'hFF;
    repeat (2800) @(posedge clk);
    @(negedge clk);
    check("timeout_not_yet", 32'(scan_timeout), 32'h0);
    repeat (800) @(posedge clk);
    @(negedge clk);
    check("timeout_raised", 32'(scan_timeout), 32'h1);
    check("timeout_value_held", 32'(value), 32'd7654);
    check("timeout_digits_held", 32'(digits), 32'h7654);
    scan_digit(0, {1'b1, seg_of(4'd4)}, 1'b0, 1'b0);
    @(negedge clk);
    check("timeout_cleared", 32'(scan_timeout), 32'h0);
    scan_digit(1, {1'b1, seg_of(4'd5)}, 1'b0, 1'b0);
    scan_digit(2, {1'b1, seg_of(4'd6)}, 1'b0, 1'b0);
    scan_digit(3, {1'b1, seg_of(4'd7)}, 1'b0, 1'b0);

    // Undecodable 7Eh on digit 2 becomes blank and latches pattern_error.
    expect_pub(16'h0031, 4'b0100, 4'h0, 14'd31);
    for (int f = 0; f < 2; f++) begin
      scan_digit(0, 8'hF9, 1'b0, 1'b0);
      scan_digit(1, 8'hB0, 1'b0, 1'b0);
      scan_digit(2, 8'hFE, 1'b0, 1'b0);
      scan_digit(3, 8'hC0, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("pattern_error_set", 32'(pattern_error), 32'h1);
    check("blank_mask_bit2", 32'(blank_mask[2]), 32'h1);

    // Reset pulse in the middle of a frame.
    scan_digit(0, 8'hF9, 1'b0, 1'b0);
    scan_digit(1, 8'hA4, 1'b0, 1'b0);
    an_in  = 4'b1011;
    seg_in = 8'hC0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    expect_pub(16'h1234, 4'h0, 4'h0, 14'd1234);
    scan_frame(16'h1234, 4'h0, 4'h0, 1'b0, 1'b0);
    scan_frame(16'h1234, 4'h0, 4'h0, 1'b0, 1'b0);
    an_in  = 4'hF;
    seg_in = 8'hFF;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("after_reset_no_pattern_error", 32'(pattern_error), 32'h0);
    check("pulse_count", 32'(n_pulses), 32'(n_pushed));
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
